urukul_spi_master: RTL and testbench
====================================

# urukul_spi_master

Host-side SPI initiator for the Urukul EEM bus. It drives `spi_sck`, the 3-bit chip-select code, and MOSI, and it captures MISO. It uses the clocking the Urukul CPLD expects: sck idles low, the CPLD samples MOSI on the rising sck edge, updates MISO on the falling edge, and shifts MSB first. It sits in the FPGA between a command/response stream and the EEM pins. Each command can address the CFG register (cs=1), the attenuators (cs=2), the DDS multicast (cs=3) or a single DDS (cs=4..7), and can chain transfers under one chip select.

## Interface
Parameters:
- `DATA_W`, 32: maximum transfer length in bits; width of the command and response data.
- `DIV_W`, 8: width of the clock-divider field.

Ports:
- `sys_clk`  in  1  system clock. One clock domain; reset is asynchronous and active-low.
- `sys_rst_n`  in  1  asynchronous active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready`.
- `cmd_data`  in  DATA_W  MOSI bits, MSB-justified; bit DATA_W-1 is sent first.
- `cmd_len`  in  6  bit count, 1..DATA_W. 0 or any value above DATA_W means DATA_W.
- `cmd_cs`  in  3  chip-select code held during the transfer.
- `cmd_div`  in  DIV_W  half-period of sck, H = cmd_div+1 sys_clk cycles.
- `cmd_end`  in  1  1 releases cs after the transfer; 0 keeps cs asserted for chaining.
- `rsp_valid`  out  1  one-cycle pulse; no backpressure.
- `rsp_data`  out  DATA_W  received bits, LSB-justified; upper bits are 0.
- `busy`  out  1  high in every state except IDLE.
- `spi_sck`, `spi_mosi`  out  1  EEM clock and data out.
- `spi_cs`  out  3  EEM chip-select code; 0 means nothing selected.
- `spi_miso`  in  1  EEM data in.

## Operation
- All SPI outputs are registered and glitch-free.
- States and their behaviour:
  - IDLE: `cmd_ready`=1, cs=0, sck=0, mosi=0.
  - SETUP: lasts H cycles. cs and the first MOSI bit are driven; sck=0.
  - HIGH: lasts H cycles with sck=1. MISO is sampled on the last cycle of the phase and shifted into the LSB of the receive register.
  - LOW: lasts H cycles with sck=0. The next MOSI bit is driven from the first cycle of the phase.
  - HOLD: lasts H cycles with sck=0, after the last bit.
  - WAIT: `cmd_ready`=1 and cs is still held.
  - GAP: lasts H cycles with cs=0.
- Transitions:
  - IDLE accept goes to SETUP.
  - SETUP goes to HIGH.
  - HIGH goes to LOW if bits remain, otherwise to HOLD.
  - LOW goes to HIGH.
  - HOLD goes to GAP if end=1, otherwise to WAIT. `rsp_valid` pulses on the first cycle after HOLD, with `rsp_data` valid on that cycle.
  - GAP goes to IDLE.
  - WAIT accept with the same cs goes to SETUP, keeping cs asserted.
  - WAIT accept with a different cs goes to GAP, then SETUP with the new cs.
- `cmd_data`, len, cs, div and end are latched on accept; later changes to the inputs have no effect.
- A bit counter counts down from len. Clamping of len happens at latch time.
- cs=0 is a legal command: sck toggles with nothing selected.
- The `rsp_data` register holds its value until the next pulse.

## Timing
- Accept in IDLE at cycle t0, with H = cmd_div+1 and n bits:
  - cs and MOSI bit 0 are valid from t0+1.
  - sck is high during cycles t0+1+H+2Hk through t0+2H+2Hk, for k = 0..n-1.
  - MOSI bit k changes at t0+1+2Hk.
  - `rsp_valid` fires at t0+1+2Hn+H.
  - With end=1, cs=0 from that same cycle. `cmd_ready` is 0 for H cycles (GAP), then 1.
- Chained transfer: accept in WAIT at cycle w; the next SETUP starts at w+1 with cs unchanged.
- Minimum cs-deasserted time is H cycles.
- After the last bit, MOSI holds that bit until cs is released or the next SETUP starts, then returns to 0.
- Reset: assertion immediately forces IDLE. In IDLE, sck=0, mosi=0, cs=0, busy=0, `rsp_valid`=0 and `rsp_data`=0. An in-flight transfer is aborted with no response. `cmd_ready`=1 from the first cycle after release.

## Test plan
- CFG write with div=0, len=24, cs=1, end=1, data=0x12345600. Required:
  - exactly 24 sck pulses;
  - MOSI reads 0x123456 at the rising edges;
  - with MISO driven from a 24-bit status model 0x080F00, `rsp_data`=0x080F00;
  - `rsp_valid` at t0+50;
  - cs=0 at t0+50.
- Div=3 (H=4), len=8. Required:
  - each sck high and low phase lasts 4 cycles;
  - `rsp_valid` at t0+69;
  - MISO is sampled on the last high cycle. A model that changes MISO on the falling edge reads back correctly.
- Chained DDS access: cs=4, len=8, end=0, then cs=4, len=32, end=1. Required:
  - cs is never 0 between the two transfers;
  - two `rsp_valid` pulses;
  - 40 sck pulses in total.
- WAIT followed by a command with cs=5. Required: cs is 0 for exactly H cycles, then 5.
- len=0 and len=40. Required: both behave as 32 bits.
- `sys_rst_n` low mid-bit. Required:
  - outputs are idle in the same cycle;
  - no `rsp_valid`;
  - a new command after release completes normally.

Source files
------------

// File: rtl/urukul_spi_master_if.sv
// Command/response stream between the host logic and the Urukul SPI initiator.
// The initiator takes the slave modport; whatever issues commands takes master.
interface urukul_spi_master_if #(
  parameter int DATA_W = 32,
  parameter int DIV_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_data;
  logic [5:0]        cmd_len;
  logic [2:0]        cmd_cs;
  logic [DIV_W-1:0]  cmd_div;
  logic              cmd_end;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_data, cmd_len, cmd_cs, cmd_div, cmd_end,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_len, cmd_cs, cmd_div, cmd_end,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/urukul_spi_master.sv
// SPI initiator for the Urukul EEM bus: sck idles low, MOSI launched on the
// falling side, MISO sampled at the end of each high phase, MSB first.
module urukul_spi_master #(
  parameter int DATA_W = 32,
  parameter int DIV_W  = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  urukul_spi_master_if.slave bus,
  output logic               busy,
  output logic               spi_sck,
  output logic               spi_mosi,
  output logic [2:0]         spi_cs,
  input  logic               spi_miso
);
  localparam int LEN_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_HIGH, S_LOW, S_HOLD, S_WAIT, S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d;
  logic [LEN_W-1:0]  bits_q, bits_d, len_clamped;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rsp_data_q, rsp_data_d;
  logic [2:0]        cs_q, cs_d, cs_lat_q, cs_lat_d;
  logic              end_q, end_d, pend_q, pend_d;
  logic              sck_q, sck_d, mosi_q, mosi_d, rsp_valid_q, rsp_valid_d;
  logic              accept, phase_done;

  assign accept     = bus.cmd_valid & bus.cmd_ready;
  assign phase_done = (cnt_q == '0);

  always_comb begin
    if (bus.cmd_len == '0 || int'(bus.cmd_len) > DATA_W) len_clamped = LEN_W'(DATA_W);
    else                                                  len_clamped = LEN_W'(bus.cmd_len);
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = phase_done ? cnt_q : cnt_q - DIV_W'(1);
    div_d       = div_q;
    bits_d      = bits_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    cs_d        = cs_q;
    cs_lat_d    = cs_lat_q;
    end_d       = end_q;
    pend_d      = pend_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;

    // Accepted fields are captured once; the bus may change freely afterwards.
    if (accept) begin
      div_d    = bus.cmd_div;
      cnt_d    = bus.cmd_div;
      end_d    = bus.cmd_end;
      cs_lat_d = bus.cmd_cs;
      tx_d     = bus.cmd_data;
      bits_d   = len_clamped;
      rx_d     = '0;
    end

    unique case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_SETUP;
        cs_d    = bus.cmd_cs;
        mosi_d  = bus.cmd_data[DATA_W-1];
      end
      S_SETUP, S_LOW: if (phase_done) begin
        state_d = S_HIGH;
        sck_d   = 1'b1;
        cnt_d   = div_q;
      end
      S_HIGH: if (phase_done) begin
        rx_d  = {rx_q[DATA_W-2:0], spi_miso};
        sck_d = 1'b0;
        cnt_d = div_q;
        if (bits_q > LEN_W'(1)) begin
          state_d = S_LOW;
          bits_d  = bits_q - LEN_W'(1);
          tx_d    = {tx_q[DATA_W-2:0], 1'b0};
          mosi_d  = tx_q[DATA_W-2];
        end else begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: if (phase_done) begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = rx_q;
        cnt_d       = div_q;
        if (end_q) begin
          state_d = S_GAP;
          cs_d    = 3'd0;
          mosi_d  = 1'b0;
          pend_d  = 1'b0;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: if (accept) begin
        if (bus.cmd_cs == cs_q) begin
          state_d = S_SETUP;
          mosi_d  = bus.cmd_data[DATA_W-1];
        end else begin
          // A new target needs cs released for one half-period first.
          state_d = S_GAP;
          cs_d    = 3'd0;
          mosi_d  = 1'b0;
          pend_d  = 1'b1;
        end
      end
      S_GAP: if (phase_done) begin
        if (pend_q) begin
          state_d = S_SETUP;
          cs_d    = cs_lat_q;
          mosi_d  = tx_q[DATA_W-1];
          cnt_d   = div_q;
          pend_d  = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      bits_q      <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      cs_q        <= 3'd0;
      cs_lat_q    <= 3'd0;
      end_q       <= 1'b0;
      pend_q      <= 1'b0;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bits_q      <= bits_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      cs_q        <= cs_d;
      cs_lat_q    <= cs_lat_d;
      end_q       <= end_d;
      pend_q      <= pend_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE) || (state_q == S_WAIT);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = (state_q != S_IDLE);
  assign spi_sck       = sck_q;
  assign spi_mosi      = mosi_q;
  assign spi_cs        = cs_q;
endmodule

// File: tb/tb_urukul_spi_master.sv
// Directed bench for urukul_spi_master: a CPLD-like MISO model plus a
// negedge monitor that records sck pulses, MOSI bits, responses and cs gaps.
module tb_urukul_spi_master;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       busy, spi_sck, spi_mosi, spi_miso;
  logic [2:0] spi_cs;

  urukul_spi_master_if #(.DATA_W(32), .DIV_W(8)) bus ();

  urukul_spi_master #(.DATA_W(32), .DIV_W(8)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus),
    .busy     (busy),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .spi_cs   (spi_cs),
    .spi_miso (spi_miso)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Written only by tasks.
  logic [31:0] miso_word = '0;
  logic        miso_req  = 1'b0;
  int          exp_h     = 0;

  // Written only by the monitor.
  logic        prev_sck = 1'b0, miso_ack = 1'b0;
  logic [31:0] miso_sr = '0, mosi_cap = '0, rsp_val = '0;
  logic [2:0]  rsp_cs = '0, cs_after_zero = '0;
  logic        rsp_ready = 1'b0, rsp_mosi = 1'b0;
  int          sck_pulses = 0, rsp_count = 0, rsp_cyc = 0, run = 0;
  int          bad_phase = 0, phase_checks = 0, zrun = 0, last_zero_run = 0, zero_cycles = 0;

  assign spi_miso = miso_sr[31];

  // The slave model shifts MISO after each falling sck edge.
  always @(negedge sys_clk) begin
    prev_sck <= spi_sck;
    if (miso_req != miso_ack) begin
      miso_sr  <= miso_word;
      miso_ack <= miso_req;
    end else if (prev_sck && !spi_sck) begin
      miso_sr <= {miso_sr[30:0], 1'b0};
    end
    if (spi_sck && !prev_sck) begin
      sck_pulses <= sck_pulses + 1;
      mosi_cap   <= {mosi_cap[30:0], spi_mosi};
    end
    if (bus.rsp_valid) begin
      rsp_count <= rsp_count + 1;
      rsp_cyc   <= cyc;
      rsp_val   <= bus.rsp_data;
      rsp_cs    <= spi_cs;
      rsp_ready <= bus.cmd_ready;
      rsp_mosi  <= spi_mosi;
    end
    if (spi_cs == 3'd0)          run <= 0;
    else if (spi_sck != prev_sck) run <= 1;
    else                          run <= run + 1;
    if (exp_h != 0 && spi_cs != 3'd0 && spi_sck != prev_sck) begin
      phase_checks <= phase_checks + 1;
      if (run != exp_h) bad_phase <= bad_phase + 1;
    end
    if (spi_cs == 3'd0) begin
      zrun        <= zrun + 1;
      zero_cycles <= zero_cycles + 1;
    end else begin
      if (zrun != 0) begin
        last_zero_run <= zrun;
        cs_after_zero <= spi_cs;
      end
      zrun <= 0;
    end
  end

  task automatic load_miso(input logic [31:0] w);
    miso_word = w;
    miso_req  = ~miso_req;
    @(negedge sys_clk); #1;
  endtask

  task automatic send(input logic [31:0] data, input logic [5:0] len, input logic [2:0] cs,
                      input logic [7:0] div, input logic e, output int t0);
    @(posedge sys_clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = data;
    bus.cmd_len   = len;
    bus.cmd_cs    = cs;
    bus.cmd_div   = div;
    bus.cmd_end   = e;
    t0 = -1;
    for (int i = 0; i < 300; i++) begin
      if (bus.cmd_ready) begin
        t0 = cyc;
        break;
      end
      @(posedge sys_clk); #1;
    end
    checks++;
    if (t0 < 0) begin
      errors++;
      $display("FAIL accept: cmd_ready never rose (cs=%0d)", cs);
    end
    @(posedge sys_clk); #1;
    // Scramble the bus so only latched values can be in use.
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = ~data;
    bus.cmd_len   = 6'd1;
    bus.cmd_cs    = 3'd7;
    bus.cmd_div   = 8'd9;
    bus.cmd_end   = ~e;
  endtask

  task automatic wait_rsp(input int target, input int budget);
    for (int i = 0; i < budget && rsp_count < target; i++) begin
      @(negedge sys_clk); #1;
    end
    checks++;
    if (rsp_count < target) begin
      errors++;
      $display("FAIL rsp_timeout: got %0d responses, need %0d", rsp_count, target);
    end
  endtask

  task automatic test_reset;
    @(posedge sys_clk); #1;
    checks++;
    if ({spi_sck, spi_mosi, spi_cs, busy, bus.rsp_valid} !== 7'b0) begin
      errors++;
      $display("FAIL reset_pins: sck/mosi/cs/busy/rsp_valid got %b want 0000000",
               {spi_sck, spi_mosi, spi_cs, busy, bus.rsp_valid});
    end
    checks++;
    if (bus.rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_rsp_data: got %h want 00000000", bus.rsp_data);
    end
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", bus.cmd_ready);
    end
  endtask

  task automatic test_cfg_write;
    int t0, p0;
    load_miso(32'h080F0000);
    p0 = sck_pulses;
    send(32'h12345600, 6'd24, 3'd1, 8'd0, 1'b1, t0);
    wait_rsp(rsp_count + 1, 200);
    checks++;
    if (sck_pulses - p0 !== 24) begin errors++; $display("FAIL cfg_pulses: got %0d want 24", sck_pulses - p0); end
    checks++;
    if (mosi_cap[23:0] !== 24'h123456) begin errors++; $display("FAIL cfg_mosi: got %h want 123456", mosi_cap[23:0]); end
    checks++;
    if (rsp_val !== 32'h00080F00) begin errors++; $display("FAIL cfg_rsp: got %h want 00080f00", rsp_val); end
    checks++;
    if (rsp_cyc - t0 !== 50) begin errors++; $display("FAIL cfg_rsp_time: got t0+%0d want t0+50", rsp_cyc - t0); end
    checks++;
    if ({rsp_cs, rsp_ready, rsp_mosi} !== 5'b0) begin
      errors++;
      $display("FAIL cfg_release: cs/ready/mosi at rsp got %b want 00000", {rsp_cs, rsp_ready, rsp_mosi});
    end
  endtask

  task automatic test_div3;
    int t0, pc0, bp0;
    load_miso(32'h3C000000);
    exp_h = 4;
    pc0 = phase_checks;
    bp0 = bad_phase;
    send(32'hA5000000, 6'd8, 3'd2, 8'd3, 1'b1, t0);
    wait_rsp(rsp_count + 1, 200);
    exp_h = 0;
    checks++;
    if (rsp_cyc - t0 !== 69) begin errors++; $display("FAIL div3_rsp_time: got t0+%0d want t0+69", rsp_cyc - t0); end
    checks++;
    if (rsp_val !== 32'h3C) begin errors++; $display("FAIL div3_rsp: got %h want 0000003c", rsp_val); end
    checks++;
    if (mosi_cap[7:0] !== 8'hA5) begin errors++; $display("FAIL div3_mosi: got %h want a5", mosi_cap[7:0]); end
    checks++;
    if (phase_checks - pc0 !== 16 || bad_phase - bp0 !== 0) begin
      errors++;
      $display("FAIL div3_phases: %0d phases, %0d not 4 cycles; want 16 and 0",
               phase_checks - pc0, bad_phase - bp0);
    end
  endtask

  task automatic test_chain;
    int t0, w, p0, r0, z0;
    load_miso(32'hC3000000);
    p0 = sck_pulses;
    r0 = rsp_count;
    send(32'h9B000000, 6'd8, 3'd4, 8'd0, 1'b0, t0);
    z0 = zero_cycles;
    wait_rsp(r0 + 1, 100);
    checks++;
    if (rsp_val !== 32'hC3) begin errors++; $display("FAIL chain_rsp1: got %h want 000000c3", rsp_val); end
    checks++;
    if ({rsp_cs, rsp_ready, rsp_mosi} !== 5'b10011) begin
      errors++;
      $display("FAIL chain_wait: cs/ready/mosi at rsp got %b want 10011", {rsp_cs, rsp_ready, rsp_mosi});
    end
    load_miso(32'hDEADBEEF);
    send(32'h0F1E2D3C, 6'd32, 3'd4, 8'd0, 1'b1, w);
    wait_rsp(r0 + 2, 200);
    checks++;
    if (rsp_val !== 32'hDEADBEEF) begin errors++; $display("FAIL chain_rsp2: got %h want deadbeef", rsp_val); end
    checks++;
    if (rsp_cyc - w !== 66) begin errors++; $display("FAIL chain_rsp2_time: got w+%0d want w+66", rsp_cyc - w); end
    checks++;
    if (sck_pulses - p0 !== 40) begin errors++; $display("FAIL chain_pulses: got %0d want 40", sck_pulses - p0); end
    checks++;
    if (mosi_cap !== 32'h0F1E2D3C) begin errors++; $display("FAIL chain_mosi: got %h want 0f1e2d3c", mosi_cap); end
    checks++;
    if (zero_cycles - z0 !== 1) begin
      errors++;
      $display("FAIL chain_cs_held: cs=0 for %0d cycles up to rsp2, want 1 (rsp2 cycle only)", zero_cycles - z0);
    end
  endtask

  task automatic test_cs_change;
    int t0, w;
    load_miso(32'h5A000000);
    send(32'hFF000000, 6'd8, 3'd3, 8'd1, 1'b0, t0);
    wait_rsp(rsp_count + 1, 100);
    load_miso(32'h96000000);
    send(32'h81000000, 6'd8, 3'd5, 8'd1, 1'b1, w);
    wait_rsp(rsp_count + 1, 100);
    checks++;
    if (last_zero_run !== 2 || cs_after_zero !== 3'd5) begin
      errors++;
      $display("FAIL cs_change_gap: cs=0 for %0d cycles then %0d, want 2 then 5", last_zero_run, cs_after_zero);
    end
    checks++;
    if (rsp_val !== 32'h96) begin errors++; $display("FAIL cs_change_rsp: got %h want 00000096", rsp_val); end
  endtask

  task automatic test_len_clamp;
    logic [5:0]  lens  [2] = '{6'd0, 6'd40};
    logic [31:0] words [2] = '{32'h12345678, 32'h87654321};
    int t0, p0;
    for (int i = 0; i < 2; i++) begin
      load_miso(words[i]);
      p0 = sck_pulses;
      send(32'h80000001, lens[i], 3'd6, 8'd0, 1'b1, t0);
      wait_rsp(rsp_count + 1, 200);
      checks++;
      if (sck_pulses - p0 !== 32 || rsp_cyc - t0 !== 66) begin
        errors++;
        $display("FAIL len%0d_clamp: %0d pulses, rsp at t0+%0d; want 32 and t0+66",
                 lens[i], sck_pulses - p0, rsp_cyc - t0);
      end
      checks++;
      if (rsp_val !== words[i] || mosi_cap !== 32'h80000001) begin
        errors++;
        $display("FAIL len%0d_data: rsp %h mosi %h; want %h and 80000001", lens[i], rsp_val, mosi_cap, words[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int t0, r0;
    load_miso(32'hFFFF0000);
    send(32'hFFFF0000, 6'd16, 3'd7, 8'd2, 1'b1, t0);
    repeat (20) @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({spi_sck, spi_mosi, spi_cs, busy, bus.rsp_valid} !== 7'b0 || bus.rsp_data !== 32'h0) begin
      errors++;
      $display("FAIL midreset_idle: sck/mosi/cs/busy/rsp_valid %b rsp_data %h; want 0",
               {spi_sck, spi_mosi, spi_cs, busy, bus.rsp_valid}, bus.rsp_data);
    end
    r0 = rsp_count;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b want 1", bus.cmd_ready); end
    repeat (150) @(posedge sys_clk);
    #1;
    checks++;
    if (rsp_count !== r0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_abort: %0d responses, busy %b; want 0 and 0", rsp_count - r0, busy);
    end
    load_miso(32'hA5000000);
    send(32'h5A000000, 6'd8, 3'd1, 8'd0, 1'b1, t0);
    wait_rsp(r0 + 1, 100);
    checks++;
    if (rsp_val !== 32'hA5 || mosi_cap[7:0] !== 8'h5A || rsp_cyc - t0 !== 18) begin
      errors++;
      $display("FAIL midreset_after: rsp %h mosi %h at t0+%0d; want 000000a5, 5a, t0+18",
               rsp_val, mosi_cap[7:0], rsp_cyc - t0);
    end
  endtask

  initial begin
    sys_rst_n     = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.cmd_len   = '0;
    bus.cmd_cs    = '0;
    bus.cmd_div   = '0;
    bus.cmd_end   = 1'b0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    test_reset;
    test_cfg_write;
    test_div3;
    test_chain;
    test_cs_change;
    test_len_clamp;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
